// File: rtl/demux_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_sched_pkg
// Brief    : Shared types, constants and helpers for the burst demux scheduler.
// Revision : 1.0
// ============================================================================
package demux_sched_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        ROUTE = 2'd2
    } state_t;

    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1x16.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x16
// Brief    : Combinational 1-to-16 bit demultiplexer (y = d << sel).
// Revision : 1.0
// ============================================================================
module demux_1x16
    import demux_sched_pkg::*;
(
    input  logic             i_d,
    input  logic [SEL_W-1:0] i_sel,
    output logic [NCH-1:0]   o_y
);

    always_comb begin
        o_y        = '0;
        o_y[i_sel] = i_d;
    end

endmodule
`default_nettype wire

// File: rtl/demux_burst_sched_find.sv
`default_nettype none
// ============================================================================
// Module   : rr_find_next
// Brief    : Wrapping priority search for the first enabled channel at/above ptr.
// Revision : 1.0
// ============================================================================
module rr_find_next
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0]   i_mask,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_nxt,
    output logic             o_found,
    output logic             o_is_last
);

    always_comb begin
        logic [SEL_W-1:0] w_idx;
        o_nxt = i_ptr;
        // Scan downward so the lowest wrapped offset wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = i_ptr + SEL_W'(i);
            if (i_mask[w_idx]) begin
                o_nxt = w_idx;
            end
        end
    end

    always_comb begin
        o_is_last = 1'b1;
        for (int j = 0; j < NCH; j++) begin
            if (i_mask[j] && (j > int'(o_nxt))) begin
                o_is_last = 1'b0;
            end
        end
    end

    assign o_found = |i_mask;

endmodule
`default_nettype wire

// File: rtl/demux_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : demux_burst_sched
// Brief    : Round-robin burst scheduler driving a 1x16 demux with registered
//            one-hot data and valid strobes.
// Revision : 1.0
// ============================================================================
module demux_burst_sched
    import demux_sched_pkg::*;
#(
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [NCH-1:0]     chan_en,
    input  logic               data_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NCH-1:0]     y,
    output logic [NCH-1:0]     y_valid,
    output logic               busy,
    output logic               frame_done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [BURST_W-1:0] r_cnt;
    logic [BURST_W-1:0] r_len_q;
    logic               r_stop_pend;
    logic               r_last_chan;
    logic [NCH-1:0]     r_y;
    logic [NCH-1:0]     r_y_valid;
    logic               r_frame_done;

    logic [SEL_W-1:0]   w_nxt;
    logic               w_found;
    logic               w_is_last;
    logic [NCH-1:0]     w_demux_y;
    logic               w_in_ready;
    logic               w_xfer;
    logic               w_last_beat;
    logic               w_seek_exit;
    logic               w_start_ok;

    rr_find_next u_find (
        .i_mask    (chan_en),
        .i_ptr     (r_ptr),
        .o_nxt     (w_nxt),
        .o_found   (w_found),
        .o_is_last (w_is_last)
    );

    demux_1x16 u_demux (
        .i_d   (data_in),
        .i_sel (r_sel),
        .o_y   (w_demux_y)
    );

    assign w_start_ok  = start && (chan_en != '0);
    assign w_seek_exit = !w_found || r_stop_pend || stop;
    assign w_last_beat = (r_cnt == (r_len_q - 1'b1));
    assign w_xfer      = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = SEEK;
                end
            end
            SEEK: begin
                w_state_nxt = w_seek_exit ? IDLE : ROUTE;
            end
            ROUTE: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last_beat) begin
                    w_state_nxt = SEEK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_sel        <= '0;
            r_cnt        <= '0;
            r_len_q      <= BURST_W'(1);
            r_stop_pend  <= 1'b0;
            r_last_chan  <= 1'b0;
            r_y          <= '0;
            r_y_valid    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_y          <= w_xfer ? w_demux_y : '0;
            r_y_valid    <= w_xfer ? onehot(r_sel) : '0;
            r_frame_done <= w_xfer && w_last_beat && r_last_chan;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len_q <= (burst_len == '0) ? BURST_W'(1) : burst_len;
                        r_ptr   <= '0;
                    end
                end
                SEEK: begin
                    if (w_seek_exit) begin
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_sel       <= w_nxt;
                        r_cnt       <= '0;
                        // Mask is only sampled here, so frame end is decided per visit.
                        r_last_chan <= w_is_last;
                    end
                end
                ROUTE: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_ptr <= r_sel + SEL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = (r_state != IDLE);
    assign sel        = r_sel;
    assign y          = r_y;
    assign y_valid    = r_y_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_burst_sched
// Brief    : Randomized scoreboard bench for demux_burst_sched.
// Revision : 1.0
// ============================================================================
module tb_demux_burst_sched;

    logic        clk = 1'b0;
    logic        rst, start, stop, data_in, in_valid;
    logic [7:0]  burst_len;
    logic [15:0] chan_en;
    logic        in_ready, busy, frame_done;
    logic [3:0]  sel;
    logic [15:0] y, y_valid;

    always #5 clk = ~clk;

    demux_burst_sched #(.BURST_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .chan_en    (chan_en),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .y          (y),
        .y_valid    (y_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        int          cyc;
        logic [15:0] yv;
        logic [15:0] yd;
        logic        fd;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    // Reference model: mode 0 = idle, 1 = choosing next channel, 2 = streaming.
    int m_mode, m_ptr, m_ch, m_cnt, m_len;
    bit m_stop, m_last;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc_n);
        end
    endtask

    function automatic int first_en(input logic [15:0] m, input int p);
        for (int i = 0; i < 16; i++) begin
            if (m[(p + i) % 16]) return (p + i) % 16;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_ch = 0; m_cnt = 0; m_len = 1;
        m_stop = 0; m_last = 0;
    endtask

    // One clock: check current-cycle outputs, advance the model, cross the edge.
    task automatic cyc();
        exp_t e;
        chk("in_ready", in_ready, (m_mode == 2));
        chk("busy", busy, (m_mode != 0));
        if (m_mode == 2) chk("sel_hold", sel, m_ch);
        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                0: if (start && chan_en != 0) begin
                    m_len  = (burst_len == 0) ? 1 : int'(burst_len);
                    m_ptr  = 0;
                    m_mode = 1;
                end
                1: if (chan_en == 0 || m_stop || stop) begin
                    m_mode = 0;
                    m_stop = 0;
                end else begin
                    m_ch   = first_en(chan_en, m_ptr);
                    m_last = ((32'(chan_en) >> (m_ch + 1)) == 0);
                    m_cnt  = 0;
                    m_mode = 2;
                end
                default: begin
                    if (stop) m_stop = 1;
                    if (in_valid) begin
                        e.cyc = cyc_n + 1;
                        e.yv  = 16'(1) << m_ch;
                        e.yd  = data_in ? (16'(1) << m_ch) : 16'h0;
                        e.fd  = (m_cnt == m_len - 1) && m_last;
                        q.push_back(e);
                        m_cnt++;
                        if (m_cnt == m_len) begin
                            m_ptr  = (m_ch + 1) % 16;
                            m_mode = 1;
                        end
                    end
                end
            endcase
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n, input int vprob);
        for (int k = 0; k < n; k++) begin
            data_in  = 1'($urandom);
            in_valid = ($urandom_range(99) < vprob);
            cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    // Monitor: outputs must match the scheduled transfer for this cycle, else be zero.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0 && q[0].cyc == cyc_n) begin
                e = q.pop_front();
                chk("y_valid", y_valid, e.yv);
                chk("y", y, e.yd);
                chk("frame_done", frame_done, e.fd);
            end else begin
                chk("idle_outputs", {y_valid, y, frame_done}, 33'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; burst_len = 8'd2;
        chan_en = 16'hFFFF; data_in = 1'b0; in_valid = 1'b0;
        model_reset();
        @(negedge clk); #1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("reset_sel", sel, 4'h0);
        chk("reset_y", y, 16'h0);
        chk("reset_y_valid", y_valid, 16'h0);
        chk("reset_frame_done", frame_done, 1'b0);

        // Full sweep, burst of 2, continuous data of ones, wrapping back to 0.
        burst_len = 8'd2; chan_en = 16'hFFFF; in_valid = 1'b1; data_in = 1'b1;
        pulse_start();
        repeat (16 * 3 + 6) cyc();
        pulse_stop();
        repeat (8) cyc();

        // Sparse mask, single-word bursts.
        chan_en = 16'h8421; burst_len = 8'd1;
        pulse_start();
        run(20, 100);
        pulse_stop();
        run(6, 100);

        // Gaps in the input stream.
        chan_en = 16'hFFFF; burst_len = 8'd3;
        pulse_start();
        run(60, 50);
        pulse_stop();
        run(12, 50);

        // Stop part-way through a 4-beat burst on channel 3.
        chan_en = 16'h0018; burst_len = 8'd4;
        pulse_start();
        run(2, 100);
        stop = 1'b1; run(1, 100); stop = 1'b0;
        run(10, 100);

        // Start with nothing enabled stays idle; burst length 0 acts as 1.
        chan_en = 16'h0000; pulse_start(); run(3, 100);
        chan_en = 16'h0005; burst_len = 8'd0;
        pulse_start(); run(10, 100); pulse_stop(); run(4, 100);

        // Mask change mid-burst on channel 0.
        chan_en = 16'h0001; burst_len = 8'd4;
        pulse_start(); run(3, 100);
        chan_en = 16'h0002; run(12, 100);
        pulse_stop(); run(5, 100);

        // Reset during a burst on channel 7, then restart.
        chan_en = 16'h0080; burst_len = 8'd4;
        pulse_start(); run(3, 100);
        rst = 1'b1; run(1, 100); rst = 1'b0;
        chk("rst_mid_y_valid", y_valid, 16'h0);
        chk("rst_mid_sel", sel, 4'h0);
        chan_en = 16'hFFFF; burst_len = 8'd2;
        pulse_start(); run(8, 100);

        // Long burst near the counter limit.
        chan_en = 16'h4000; burst_len = 8'd255;
        pulse_start(); run(300, 90);
        pulse_stop(); run(300, 100);

        // Unconstrained random traffic with occasional control pulses.
        for (int k = 0; k < 1500; k++) begin
            rst   = ($urandom_range(199) == 0);
            start = ($urandom_range(99) < 4);
            stop  = ($urandom_range(99) < 2);
            if ($urandom_range(19) == 0) chan_en = 16'($urandom) & 16'($urandom);
            if ($urandom_range(19) == 0) burst_len = 8'($urandom_range(4));
            data_in  = 1'($urandom);
            in_valid = ($urandom_range(99) < 70);
            cyc();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        repeat (3) cyc();
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_burst_sched.md
Name: demux_burst_sched

Overview:
- Round-robin scheduler that sequences the demux_1x16 datapath.
- Accepts a 1-bit valid/ready input stream and routes bursts of burst_len words to each enabled channel in turn, driving the demux select.
- Outputs are registered one-hot data and valid strobes.
- Sits between a serial source and 16 per-channel consumers.

Parameters:
- NCH, 16, number of output channels; fixed at 16 to match demux_1x16.
- SEL_W, 4, select width; log2(NCH).
- BURST_W, 8, width of the burst length and beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins scheduling from channel 0.
- stop  in  1  pulse; requests a graceful halt.
- burst_len  in  BURST_W  words per channel visit; latched on start; a value of 0 is treated as 1.
- chan_en  in  NCH  channel enable mask; sampled only in SEEK.
- data_in  in  1  serial data bit.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  scheduler accepts data; asserted only in ROUTE.
- sel  out  SEL_W  current channel, registered; drives demux_1x16 sel.
- y  out  NCH  registered demux output, i.e. data_in<<sel on a transfer, else 0.
- y_valid  out  NCH  one-hot strobe 1<<sel on a transfer, else 0.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  1-cycle pulse after the burst to the highest-indexed enabled channel completes.

Behaviour:
- Reset: state=IDLE, ptr=0, cnt=0, len_q=1, sel=0, y=0, y_valid=0, in_ready=0, busy=0, frame_done=0, stop_pend=0.
- States: IDLE, SEEK, ROUTE.
- IDLE:
  - in_ready=0.
  - On start with chan_en!=0: latch len_q=max(burst_len,1), set ptr=0, go to SEEK.
  - On start with chan_en==0: stay in IDLE.
- SEEK (exactly 1 cycle):
  - nxt = first enabled channel at or above ptr, wrapping 15->0.
  - If chan_en==0 or stop_pend: go to IDLE and clear stop_pend.
  - Otherwise: sel<=nxt, cnt<=0, go to ROUTE.
- ROUTE:
  - in_ready=1.
  - On a transfer (in_valid&in_ready): y<=data_in<<sel, y_valid<=1<<sel, cnt<=cnt+1. Latency is 1 cycle from the accept edge to y/y_valid.
  - With no transfer: y=0, y_valid=0, state holds.
  - On the transfer with cnt==len_q-1: ptr<=(sel+1) mod 16, go to SEEK.
  - frame_done pulses 1 cycle with that last transfer's y_valid when no enabled channel exists above sel.
- Throughput: one SEEK bubble per burst; peak rate is len_q/(len_q+1).
- stop:
  - In ROUTE: sets stop_pend; the current burst completes, then SEEK exits to IDLE.
  - In SEEK: takes effect the same cycle.
  - In IDLE: ignored.
  - stop and start together in IDLE: start wins; stop is ignored.
- start while busy is ignored.
- chan_en changes mid-burst do not abort the burst; the new mask applies at the next SEEK.
- rst mid-burst: all state and outputs return to reset values on the next edge; the partial burst is discarded.
- cnt width is BURST_W. len_q=2^BURST_W-1 (255) must not overflow; the comparison uses len_q-1.
- sel is stable throughout ROUTE and changes only on the SEEK edge.

Decomposition:
- Package demux_sched_pkg:
  - state enum {IDLE, SEEK, ROUTE};
  - constants NCH=16 and SEL_W=4;
  - function onehot(sel).
- Sub-module rr_find_next: combinational wrapping priority search.
  - Inputs: mask[15:0], ptr[3:0].
  - Outputs: nxt[3:0], found, is_last (no enabled channel above nxt).
- demux_1x16 is instantiated for y generation; its output is gated by the transfer and registered.

Test Plan:
- Basic sweep: rst then start, chan_en=16'hFFFF, burst_len=2, in_valid=1, data_in=1 -> y_valid walks 0x0001,0x0001,(bubble),0x0002,0x0002 ... 0x8000; frame_done on the 32nd transfer; wrap to channel 0.
- Sparse mask: chan_en=16'h8421, burst_len=1 -> channel order 0,5,10,15,0; frame_done after channel 15; y_valid 0x0001,0x0020,0x0400,0x8000.
- Backpressure/gaps: in_valid toggled 1,0,1, burst_len=3 -> cnt advances only on valid, sel held for 5 cycles, y=0 on idle cycles.
- Stop mid-burst: stop at beat 1 of 4 on channel 3 -> beats 2-4 complete on channel 3, then IDLE, busy=0, in_ready=0, no visit to channel 4.
- Edge cases: start with chan_en=0 -> stays IDLE; burst_len=0 -> behaves as 1; mask changed to 16'h0002 mid-burst on channel 0 -> channel 0 burst completes, next is channel 1.
- Reset mid-burst: rst on beat 2 of channel 7 -> next cycle all outputs 0, state IDLE; a following start begins at channel 0.
